// File: rtl/cpu_stack_core_if.sv
// Flash reader and text-screen ports of the stack CPU, bundled so the core
// and its neighbours share one definition of the handshake.
interface cpu_stack_core_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] flashReadAddr;
    logic              enableFlash;
    logic [7:0]        flashByteRead;
    logic              flashDataReady;
    logic [7:0]        cpuChar;
    logic [5:0]        cpuCharIndex;
    logic              writeScreen;

    modport master (
        output flashReadAddr, enableFlash, cpuChar, cpuCharIndex, writeScreen,
        input  flashByteRead, flashDataReady
    );

    modport slave (
        input  flashReadAddr, enableFlash, cpuChar, cpuCharIndex, writeScreen,
        output flashByteRead, flashDataReady
    );
endinterface

// File: rtl/cpu_stack_core.sv
// Flash-fed accumulator CPU with register file, carry, jumps, bounded return stack.
//
// state        | meaning
// FETCH        | issue flash read of instruction byte at pc
// F_WAIT_START | wait for flash reader to go busy
// F_WAIT_DONE  | wait for data, capture instruction, pc+1
// DECODE       | latch register operand, pick immediate or execute
// RETRIEVE     | issue flash read of immediate byte at pc
// R_WAIT_START | wait for flash reader to go busy
// R_WAIT_DONE  | wait for data, capture immediate, pc+1
// EXECUTE      | perform the opcode
// PRINT_ACK    | screen write strobe cycle
// WAIT         | down-count WAIT delay
// HALT         | terminal until reset
module cpu_stack_core #(
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 11,
    parameter int NUM_REGS    = 4,
    parameter int STACK_DEPTH = 4,
    parameter int WAIT_TICKS  = 27000
) (
    input  logic             clk,
    input  logic             reset,
    cpu_stack_core_if.master bus,
    input  logic             btn,
    output logic [5:0]       leds,
    output logic             halted,
    output logic             fault
);
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int TICK_W = $clog2(WAIT_TICKS + 1);
    localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);
    localparam logic [TICK_W-1:0] TICK_LOAD = TICK_W'(WAIT_TICKS - 1);

    localparam logic [3:0] OP_NOP  = 4'd0,  OP_LDA  = 4'd1,  OP_ADD  = 4'd2,  OP_SUB  = 4'd3;
    localparam logic [3:0] OP_STA  = 4'd4,  OP_INV  = 4'd5,  OP_LED  = 4'd6,  OP_PRNT = 4'd7;
    localparam logic [3:0] OP_JMP  = 4'd8,  OP_JMPZ = 4'd9,  OP_JMPC = 4'd10, OP_CALL = 4'd11;
    localparam logic [3:0] OP_RET  = 4'd12, OP_WAIT = 4'd13, OP_BTN  = 4'd14, OP_HLT  = 4'd15;

    typedef enum logic [3:0] {
        FETCH, F_WAIT_START, F_WAIT_DONE, DECODE,
        RETRIEVE, R_WAIT_START, R_WAIT_DONE, EXECUTE,
        PRINT_ACK, WAIT, HALT
    } state_t;

    state_t state, state_n;

    logic [ADDR_W-1:0] pc, pc_n;
    logic [DATA_W-1:0] regs   [NUM_REGS];
    logic [DATA_W-1:0] regs_n [NUM_REGS];
    logic              carry, carry_n;
    logic [SP_W-1:0]   sp, sp_n;
    logic [ADDR_W-1:0] stack   [STACK_DEPTH];
    logic [ADDR_W-1:0] stack_n [STACK_DEPTH];
    logic [7:0]        instr, instr_n;
    logic [DATA_W-1:0] op, op_n;
    logic [ADDR_W-1:0] flash_addr, flash_addr_n;
    logic              en_flash, en_flash_n;
    logic [5:0]        leds_n;
    logic [7:0]        char_q, char_n;
    logic [5:0]        char_idx, char_idx_n;
    logic              wr_scr, wr_scr_n;
    logic              fault_n;
    logic [TICK_W-1:0] tick, tick_n;
    logic [DATA_W-1:0] units, units_n;

    logic [3:0]        opcode;
    logic [2:0]        sel;
    logic [DATA_W-1:0] rd_val;
    logic [ADDR_W-1:0] op_addr;
    logic [ADDR_W-1:0] stack_top;

    assign opcode  = instr[6:3];
    assign sel     = instr[2:0];
    assign op_addr = ADDR_W'(op);

    assign bus.flashReadAddr = flash_addr;
    assign bus.enableFlash   = en_flash;
    assign bus.cpuChar       = char_q;
    assign bus.cpuCharIndex  = char_idx;
    assign bus.writeScreen   = wr_scr;
    assign halted            = (state == HALT);

    // Selects beyond the implemented register file read as zero.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (sel == 3'(i)) rd_val = regs[i];
    end

    always_comb begin
        stack_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp == SP_W'(i + 1)) stack_top = stack[i];
    end

    always_comb begin
        state_n      = state;
        pc_n         = pc;
        regs_n       = regs;
        carry_n      = carry;
        sp_n         = sp;
        stack_n      = stack;
        instr_n      = instr;
        op_n         = op;
        flash_addr_n = flash_addr;
        en_flash_n   = en_flash;
        leds_n       = leds;
        char_n       = char_q;
        char_idx_n   = char_idx;
        wr_scr_n     = 1'b0;
        fault_n      = fault;
        tick_n       = tick;
        units_n      = units;

        case (state)
            FETCH: begin
                if (!en_flash) begin
                    flash_addr_n = pc;
                    en_flash_n   = 1'b1;
                    state_n      = F_WAIT_START;
                end
            end
            F_WAIT_START: if (!bus.flashDataReady) state_n = F_WAIT_DONE;
            F_WAIT_DONE: begin
                if (bus.flashDataReady) begin
                    instr_n    = bus.flashByteRead;
                    en_flash_n = 1'b0;
                    pc_n       = pc + ADDR_W'(1);
                    state_n    = DECODE;
                end
            end
            DECODE: begin
                op_n    = rd_val;
                state_n = instr[7] ? RETRIEVE : EXECUTE;
            end
            RETRIEVE: begin
                if (!en_flash) begin
                    flash_addr_n = pc;
                    en_flash_n   = 1'b1;
                    state_n      = R_WAIT_START;
                end
            end
            R_WAIT_START: if (!bus.flashDataReady) state_n = R_WAIT_DONE;
            R_WAIT_DONE: begin
                if (bus.flashDataReady) begin
                    op_n       = DATA_W'(bus.flashByteRead);
                    en_flash_n = 1'b0;
                    pc_n       = pc + ADDR_W'(1);
                    state_n    = EXECUTE;
                end
            end
            EXECUTE: begin
                state_n = FETCH;
                case (opcode)
                    OP_NOP: ;
                    OP_LDA: regs_n[0] = op;
                    OP_ADD: {carry_n, regs_n[0]} = {1'b0, regs[0]} + {1'b0, op};
                    OP_SUB: {carry_n, regs_n[0]} = {1'b0, regs[0]} - {1'b0, op};
                    OP_STA: begin
                        for (int i = 1; i < NUM_REGS; i++)
                            if (sel == 3'(i)) regs_n[i] = regs[0];
                    end
                    OP_INV: begin
                        for (int i = 0; i < NUM_REGS; i++)
                            if (sel == 3'(i)) regs_n[i] = ~regs[i];
                    end
                    OP_LED: leds_n = ~regs[0][5:0];
                    OP_PRNT: begin
                        char_idx_n = regs[0][5:0];
                        char_n     = op[7:0];
                        wr_scr_n   = 1'b1;
                        state_n    = PRINT_ACK;
                    end
                    OP_JMP:  pc_n = op_addr;
                    OP_JMPZ: if (regs[0] == '0) pc_n = op_addr;
                    OP_JMPC: if (carry) pc_n = op_addr;
                    OP_CALL: begin
                        if (sp == SP_FULL) begin
                            fault_n = 1'b1;
                            state_n = HALT;
                        end else begin
                            for (int i = 0; i < STACK_DEPTH; i++)
                                if (sp == SP_W'(i)) stack_n[i] = pc;
                            sp_n = sp + SP_W'(1);
                            pc_n = op_addr;
                        end
                    end
                    OP_RET: begin
                        if (sp == '0) begin
                            fault_n = 1'b1;
                            state_n = HALT;
                        end else begin
                            pc_n = stack_top;
                            sp_n = sp - SP_W'(1);
                        end
                    end
                    // units counts the remaining whole WAIT_TICKS periods after this one
                    OP_WAIT: begin
                        units_n = op;
                        tick_n  = TICK_LOAD;
                        state_n = WAIT;
                    end
                    OP_BTN: regs_n[0] = btn ? '0 : DATA_W'(1);
                    OP_HLT: state_n = HALT;
                    default: ;
                endcase
            end
            PRINT_ACK: state_n = FETCH;
            WAIT: begin
                if (tick == '0) begin
                    if (units == '0) begin
                        state_n = FETCH;
                    end else begin
                        units_n = units - DATA_W'(1);
                        tick_n  = TICK_LOAD;
                    end
                end else begin
                    tick_n = tick - TICK_W'(1);
                end
            end
            HALT: ;
            default: state_n = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            pc         <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            carry      <= 1'b0;
            sp         <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
            instr      <= '0;
            op         <= '0;
            flash_addr <= '0;
            en_flash   <= 1'b0;
            leds       <= 6'b111111;
            char_q     <= '0;
            char_idx   <= '0;
            wr_scr     <= 1'b0;
            fault      <= 1'b0;
            tick       <= '0;
            units      <= '0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            regs       <= regs_n;
            carry      <= carry_n;
            sp         <= sp_n;
            stack      <= stack_n;
            instr      <= instr_n;
            op         <= op_n;
            flash_addr <= flash_addr_n;
            en_flash   <= en_flash_n;
            leds       <= leds_n;
            char_q     <= char_n;
            char_idx   <= char_idx_n;
            wr_scr     <= wr_scr_n;
            fault      <= fault_n;
            tick       <= tick_n;
            units      <= units_n;
        end
    end
endmodule

// File: tb/tb_cpu_stack_core.sv
// Directed bench for cpu_stack_core: small flash responder plus hand-written programs.
module tb_cpu_stack_core;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn = 1'b1;
    logic [5:0] leds;
    logic       halted;
    logic       fault;

    cpu_stack_core_if #(.ADDR_W(11)) bus ();

    cpu_stack_core #(
        .DATA_W(8), .ADDR_W(11), .NUM_REGS(4), .STACK_DEPTH(4), .WAIT_TICKS(10)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .btn(btn),
        .leds(leds), .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    int ntests = 0;
    int nfail  = 0;

    logic [7:0]  mem [2048];
    int          fl_phase = 0;
    int          fl_cnt = 0;
    bit          fl_stall = 1'b0;
    logic [10:0] fl_addr = '0;
    logic [10:0] fetch_log [$];
    int          cyc = 0;
    int          en_fall_cyc = 0;
    int          last_gap = 0;
    int          scr_cnt = 0;
    logic [7:0]  scr_char = '0;
    logic [5:0]  scr_idx = '0;

    initial begin
        bus.flashDataReady = 1'b1;
        bus.flashByteRead  = 8'h00;
    end

    // Flash reader: go busy after a request, return data two cycles later.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            fl_phase = 0;
            bus.flashDataReady = 1'b1;
        end else begin
            case (fl_phase)
                0: if (bus.enableFlash) begin
                    fl_addr = bus.flashReadAddr;
                    fetch_log.push_back(fl_addr);
                    last_gap = cyc - en_fall_cyc;
                    bus.flashDataReady = 1'b0;
                    fl_cnt = 2;
                    fl_phase = 1;
                end
                1: if (!fl_stall) begin
                    if (fl_cnt == 0) begin
                        bus.flashByteRead  = mem[fl_addr];
                        bus.flashDataReady = 1'b1;
                        fl_phase = 2;
                    end else begin
                        fl_cnt--;
                    end
                end
                default: if (!bus.enableFlash) begin
                    en_fall_cyc = cyc;
                    fl_phase = 0;
                end
            endcase
        end
        if (bus.writeScreen) begin
            scr_cnt++;
            scr_char = bus.cpuChar;
            scr_idx  = bus.cpuCharIndex;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 2048; i++) mem[i] = 8'h78;
    endtask

    task automatic poke(input int a, input logic [7:0] b);
        mem[a] = b;
    endtask

    task automatic restart();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        fetch_log.delete();
        scr_cnt = 0;
        reset = 1'b0;
    endtask

    task automatic run_until_halt(input string tag, input int max_cycles);
        int n = 0;
        while (!halted && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_halted"}, halted, 1);
    endtask

    initial begin
        int en_hi;
        clear_mem();
        repeat (3) @(negedge clk);

        check("rst_pc",     dut.pc, 0);
        check("rst_ac",     dut.regs[0], 0);
        check("rst_sp",     dut.sp, 0);
        check("rst_leds",   leds, 6'b111111);
        check("rst_en",     bus.enableFlash, 0);
        check("rst_addr",   bus.flashReadAddr, 0);
        check("rst_wr",     bus.writeScreen, 0);
        check("rst_char",   {bus.cpuChar, 2'b00, bus.cpuCharIndex}, 0);
        check("rst_status", {halted, fault}, 0);

        // LDA #5; ADD #3; LED; NOP; HLT
        clear_mem();
        poke(0, 8'h88); poke(1, 8'h05); poke(2, 8'h90); poke(3, 8'h03);
        poke(4, 8'h30); poke(5, 8'h00); poke(6, 8'h78);
        restart();
        run_until_halt("t1", 500);
        check("t1_leds",  leds, 6'b110111);
        check("t1_pc",    dut.pc, 7);
        check("t1_carry", dut.carry, 0);
        check("t1_fault", fault, 0);

        // LDA #2; SUB #3; JMPC 0x20
        clear_mem();
        poke(0, 8'h88); poke(1, 8'h02); poke(2, 8'h98); poke(3, 8'h03);
        poke(4, 8'hD0); poke(5, 8'h20); poke(6, 8'h00);
        restart();
        run_until_halt("t2", 500);
        check("t2_ac",    dut.regs[0], 8'hFF);
        check("t2_carry", dut.carry, 1);
        check("t2_jaddr", fetch_log[fetch_log.size()-1], 11'h020);
        check("t2_pc",    dut.pc, 11'h021);

        // CALL 0x10; HLT / 0x10: RET
        clear_mem();
        poke(0, 8'hD8); poke(1, 8'h10); poke(2, 8'h78); poke(16, 8'h60);
        restart();
        run_until_halt("t3a", 500);
        check("t3a_nfetch", fetch_log.size(), 4);
        check("t3a_ret",    fetch_log[3], 2);
        check("t3a_sp",     dut.sp, 0);
        check("t3a_pc",     dut.pc, 3);
        check("t3a_fault",  fault, 0);

        // Four nested calls fill the stack, four RETs unwind back to 2.
        clear_mem();
        poke(0, 8'hD8);    poke(1, 8'h10);    poke(2, 8'h78);
        poke(16, 8'hD8);   poke(17, 8'h20);   poke(18, 8'h60);
        poke(32, 8'hD8);   poke(33, 8'h30);   poke(34, 8'h60);
        poke(48, 8'hD8);   poke(49, 8'h40);   poke(50, 8'h60);
        poke(64, 8'h60);
        restart();
        run_until_halt("t3b", 1000);
        check("t3b_fault", fault, 0);
        check("t3b_sp",    dut.sp, 0);
        check("t3b_pc",    dut.pc, 3);

        // Five chained calls: the fifth overflows.
        clear_mem();
        for (int i = 0; i < 5; i++) begin
            poke(2*i, 8'hD8);
            poke(2*i + 1, 8'(2*i + 2));
        end
        restart();
        run_until_halt("t3c", 1000);
        check("t3c_fault", fault, 1);
        check("t3c_sp",    dut.sp, 4);
        check("t3c_pc",    dut.pc, 10);

        // RET on empty stack
        clear_mem();
        poke(0, 8'h60);
        restart();
        run_until_halt("t4", 200);
        check("t4_fault", fault, 1);
        check("t4_pc",    dut.pc, 1);
        en_hi = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.enableFlash) en_hi++;
        end
        check("t4_no_fetch", en_hi, 0);
        check("t4_still_halted", halted, 1);

        // LDA #3; PRNT #'A'; WAIT #1; HLT
        clear_mem();
        poke(0, 8'h88); poke(1, 8'h03); poke(2, 8'hB8); poke(3, 8'h41);
        poke(4, 8'hE8); poke(5, 8'h01); poke(6, 8'h78);
        restart();
        run_until_halt("t5", 500);
        check("t5_strobes", scr_cnt, 1);
        check("t5_idx",     scr_idx, 3);
        check("t5_char",    scr_char, 8'h41);
        check("t5_wr_low",  bus.writeScreen, 0);
        // enable drop on operand capture -> 1 EXECUTE + 20 WAIT + 1 FETCH cycles -> enable rise
        check("t5_wait_gap", last_gap, 22);

        // BTN (pressed); STA r1; INV r1; LDA r7 (reads 0); JMPZ 8
        clear_mem();
        poke(0, 8'h70); poke(1, 8'h21); poke(2, 8'h29); poke(3, 8'h0F);
        poke(4, 8'hC8); poke(5, 8'h08); poke(6, 8'h78); poke(8, 8'h78);
        btn = 1'b0;
        restart();
        run_until_halt("t7", 500);
        btn = 1'b1;
        check("t7_r1", dut.regs[1], 8'hFE);
        check("t7_ac", dut.regs[0], 0);
        check("t7_pc", dut.pc, 9);

        // Reset while the instruction read is stalled in F_WAIT_DONE
        clear_mem();
        poke(0, 8'h88); poke(1, 8'h05); poke(2, 8'h78);
        fl_stall = 1'b1;
        restart();
        repeat (6) @(negedge clk);
        check("t6_pre_en", bus.enableFlash, 1);
        check("t6_pre_rdy", bus.flashDataReady, 0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_en_drop", bus.enableFlash, 0);
        check("t6_pc",      dut.pc, 0);
        fl_stall = 1'b0;
        fetch_log.delete();
        @(negedge clk);
        reset = 1'b0;
        run_until_halt("t6", 500);
        check("t6_first_addr", fetch_log[0], 0);
        check("t6_ac", dut.regs[0], 5);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/cpu_stack_core.md
Name: cpu_stack_core

Overview:
- Parametrised successor to the team's 8-bit flash-fed accumulator CPU.
- Fetches byte-wide instructions from the external flash reader using the enable/ready handshake.
- Drives the LED bank and the text-screen write port.
- Adds over the previous core: configurable data width and register count, SUB with a carry flag, unconditional and carry jumps, CALL/RET on a bounded return stack, and a fault/halted status.

Parameters:
- DATA_W, 8, accumulator/register width (>=8); flash immediates are zero-extended.
- ADDR_W, 11, program counter and flash address width.
- NUM_REGS, 4, general registers r1..r(NUM_REGS-1) plus ac as r0; 2..8.
- STACK_DEPTH, 4, return-stack entries; 1..16.
- WAIT_TICKS, 27000, clk cycles per WAIT unit.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flashReadAddr  out  ADDR_W  flash byte address
- enableFlash  out  1  read request, held until data captured
- flashByteRead  in  8  flash data
- flashDataReady  in  1  flash reader idle/data-valid
- btn  in  1  user button, active-low raw level
- leds  out  6  LED drive, active-low
- cpuChar  out  8  character to print
- cpuCharIndex  out  6  screen cell index
- writeScreen  out  1  one-cycle screen write strobe
- halted  out  1  high in HALT state
- fault  out  1  sticky: stack overflow/underflow

Behaviour:
Reset values:
- pc=0, ac/regs/carry=0, sp=0, flashReadAddr=0, enableFlash=0, leds=6'b111111, cpuChar=0, cpuCharIndex=0, writeScreen=0, halted=0, fault=0.
- Next state is FETCH.
- A reset mid-operation aborts any flash read: enableFlash drops in the cycle after reset is sampled.

Instruction byte format:
- [7] imm: operand is the next flash byte, zero-extended.
- [6:3] opcode.
- [2:0] register select s. Without imm, operand = r[s]; s>=NUM_REGS reads 0, writes ignored.

Flash read (shared by FETCH and RETRIEVE):
- Drive address and enableFlash=1.
- Wait for flashDataReady=0, then flashDataReady=1.
- Capture flashByteRead and drop enableFlash in the same cycle.
- A new request is never issued while enableFlash=1.

States:
- FETCH -> F_WAIT_START -> F_WAIT_DONE -> DECODE (pc+1).
- DECODE -> RETRIEVE chain (pc+1 after capture) if imm, else EXECUTE.
- EXECUTE -> FETCH, except PRINT -> PRINT_ACK (strobe), WAIT -> WAIT, HLT/fault -> HALT.

Opcodes, results visible the cycle after EXECUTE:
- 0 NOP.
- 1 LDA: ac=op.
- 2 ADD: {carry,ac}=ac+op.
- 3 SUB: {carry,ac}=ac-op; carry=1 on borrow.
- 4 STA: r[s]=ac; s=0 is a no-op.
- 5 INV: r[s]=~r[s].
- 6 LED: leds=~ac[5:0].
- 7 PRNT: cpuCharIndex=ac[5:0], cpuChar=op[7:0], writeScreen=1 for exactly one cycle.
- 8 JMP: pc=op[ADDR_W-1:0] zero-extended.
- 9 JMPZ: jump if ac==0.
- 10 JMPC: jump if carry.
- 11 CALL: push return pc (address after the instruction), then jump. If sp==STACK_DEPTH: fault=1, go to HALT, pc unchanged.
- 12 RET: pop to pc. If sp==0: fault=1, go to HALT.
- 13 WAIT: wait (op+1)*WAIT_TICKS cycles. op=0 gives WAIT_TICKS cycles; the counter is DATA_W wide, no wrap issue.
- 14 BTN: ac=btn?0:1.
- 15 HLT.

Stack and HALT:
- Stack is ADDR_W wide. sp counts 0..STACK_DEPTH; a full stack followed by RET returns correctly.
- HALT is terminal until reset; halted=1.

Test Plan:
1. imm LDA 5; imm ADD 3; LED; HLT -> leds=~6'd8=6'b110111, halted=1, pc=7.
2. imm LDA 2; imm SUB 3 -> ac=0xFF, carry=1; JMPC 0x20 -> next fetch flashReadAddr=0x20.
3. CALL 0x10; subroutine at 0x10 is RET -> next fetch at address 2; sp back to 0. Nest STACK_DEPTH+1 CALLs -> fault=1, halted=1 on the last.
4. RET with empty stack -> fault=1, halted=1, no further enableFlash.
5. ac=3; imm PRNT 'A' (0x41) -> single-cycle writeScreen with cpuCharIndex=3, cpuChar=0x41. WAIT with WAIT_TICKS=10, op=1 -> next fetch 20±2 cycles later.
6. Reset asserted while in F_WAIT_DONE with flashDataReady=0 -> enableFlash=0 next cycle, pc=0, first fetch address 0 afterwards.
